// File: rtl/pingpang_pkg.sv
// Shared definitions for the ping-pong buffer feeder: FSM encoding,
// channel constants and default sample width.
package pingpang_pkg;

    localparam int unsigned DEF_DW = 16;

    // Channel tags match the buffer's switch polarity.
    localparam logic CH_A = 1'b0;
    localparam logic CH_B = 1'b1;

    typedef enum logic [3:0] {
        StIdle   = 4'b0001,
        StStream = 4'b0010,
        StGuard  = 4'b0100,
        StSettle = 4'b1000
    } state_e;

endpackage

// File: rtl/pingpang_idle_timer.sv
// Loadable down-counter; done is high during the last counted cycle.
module pingpang_idle_timer #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    // Not gated by load: the owner reloads on done to chain windows back to back.
    assign done = (cnt_q == W'(1));

endmodule

// File: rtl/pingpang_feeder.sv
// Feeds framed samples into the ping-pong buffer, inserting idle guard/settle
// windows around every switch change and policing frame length.
module pingpang_feeder
    import pingpang_pkg::*;
#(
    parameter int unsigned DW         = DEF_DW,
    parameter int unsigned FRAME_LEN  = 8,
    parameter int unsigned CNT_W      = 8,
    parameter int unsigned GUARD_CYC  = 2,
    parameter int unsigned SETTLE_CYC = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [DW-1:0] s_data,
    input  logic          s_chan,
    input  logic          s_last,
    output logic          data_en,
    output logic [DW-1:0] data_in_a,
    output logic [DW-1:0] data_in_b,
    output logic          switch,
    output logic          frame_done,
    output logic          err_short,
    output logic          err_long,
    input  logic          err_clr
);

    localparam int unsigned TW = 8;
    localparam logic [CNT_W-1:0] LEN = CNT_W'(FRAME_LEN);

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_inc;
    logic             chan_match;
    logic             accept;
    logic             tmr_load;
    logic             tmr_done;
    logic [TW-1:0]    tmr_val;

    assign chan_match = (s_chan == switch);

    // Ready is forced low while reset is held, since IDLE readiness is combinational.
    assign s_ready = (state_q == StStream) || ((state_q == StIdle) && chan_match && rst_n);
    assign accept  = s_valid && s_ready;

    assign cnt_inc = (state_q == StIdle) ? CNT_W'(1) : cnt_q + CNT_W'(1);

    assign tmr_load = ((state_q == StIdle) && s_valid && !chan_match) ||
                      ((state_q == StGuard) && tmr_done);
    assign tmr_val  = (state_q == StIdle) ? TW'(GUARD_CYC) : TW'(SETTLE_CYC);

    pingpang_idle_timer #(
        .W (TW)
    ) u_idle_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            data_en    <= 1'b0;
            data_in_a  <= '0;
            data_in_b  <= '0;
            switch     <= CH_A;
            frame_done <= 1'b0;
            err_short  <= 1'b0;
            err_long   <= 1'b0;
        end else begin
            data_en    <= accept;
            frame_done <= 1'b0;
            if (err_clr) begin
                err_short <= 1'b0;
                err_long  <= 1'b0;
            end
            if (accept) begin
                if (switch == CH_A) begin
                    data_in_a <= s_data;
                end else begin
                    data_in_b <= s_data;
                end
                // Error sets come after the clear so they win in the same cycle.
                if (s_last || (cnt_inc == LEN)) begin
                    frame_done <= 1'b1;
                    cnt_q      <= '0;
                    state_q    <= StIdle;
                    if (s_last && (cnt_inc < LEN)) begin
                        err_short <= 1'b1;
                    end
                    if (!s_last) begin
                        err_long <= 1'b1;
                    end
                end else begin
                    cnt_q   <= cnt_inc;
                    state_q <= StStream;
                end
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (s_valid) begin
                            state_q <= StGuard;
                        end
                    end
                    StStream: ;
                    StGuard: begin
                        if (tmr_done) begin
                            switch  <= (switch == CH_A) ? CH_B : CH_A;
                            state_q <= StSettle;
                        end
                    end
                    StSettle: begin
                        if (tmr_done) begin
                            state_q <= StIdle;
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pingpang_feeder.sv
// Randomised and directed bench for pingpang_feeder against a cycle-level
// behavioural model built from the frame/switch rules.
module tb_pingpang_feeder;

    localparam int FL = 8;
    localparam int G  = 2;
    localparam int S  = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        s_valid, s_ready, s_chan, s_last, err_clr;
    logic [15:0] s_data;
    logic        data_en, switch, frame_done, err_short, err_long;
    logic [15:0] data_in_a, data_in_b;

    always #5 clk = ~clk;

    pingpang_feeder #(
        .DW         (16),
        .FRAME_LEN  (FL),
        .CNT_W      (8),
        .GUARD_CYC  (G),
        .SETTLE_CYC (S)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .s_chan     (s_chan),
        .s_last     (s_last),
        .data_en    (data_en),
        .data_in_a  (data_in_a),
        .data_in_b  (data_in_b),
        .switch     (switch),
        .frame_done (frame_done),
        .err_short  (err_short),
        .err_long   (err_long),
        .err_clr    (err_clr)
    );

    // phase: 0 idle, 1 mid-frame, 2 blocked by a channel change (wait_c cycles left)
    typedef struct {
        logic        sw;
        logic [15:0] a;
        logic [15:0] b;
        logic        en;
        logic        done;
        logic        es;
        logic        el;
        int          phase;
        int          wait_c;
        int          cnt;
    } mst_t;

    mst_t m;
    int   checks = 0;
    int   fails = 0;
    int   n_done = 0;
    bit   run = 0;
    bit   rnd_clr = 0;

    function automatic mst_t reset_m();
        mst_t r;
        r.sw = 0; r.a = '0; r.b = '0; r.en = 0; r.done = 0; r.es = 0; r.el = 0;
        r.phase = 0; r.wait_c = 0; r.cnt = 0;
        return r;
    endfunction

    function automatic logic rdy(mst_t s, logic ch);
        return (s.phase == 1) || ((s.phase == 0) && (ch == s.sw));
    endfunction

    function automatic mst_t step(mst_t s, logic v, logic ch, logic [15:0] d, logic last,
                                  logic clr);
        mst_t n;
        logic acc;
        n = s;
        acc = v && rdy(s, ch);
        n.en = acc;
        n.done = 0;
        if (clr) begin
            n.es = 0;
            n.el = 0;
        end
        if (s.phase == 2) begin
            n.wait_c = s.wait_c - 1;
            if (n.wait_c == S) n.sw = ~s.sw;
            if (n.wait_c == 0) n.phase = 0;
        end else if (s.phase == 0 && v && ch != s.sw) begin
            n.phase = 2;
            n.wait_c = G + S;
        end
        if (acc) begin
            if (s.sw == 1'b0) n.a = d;
            else n.b = d;
            n.cnt = ((s.phase == 0) ? 0 : s.cnt) + 1;
            if (last || n.cnt == FL) begin
                n.done = 1;
                if (last && n.cnt < FL) n.es = 1;
                if (!last) n.el = 1;
                n.phase = 0;
                n.cnt = 0;
            end else begin
                n.phase = 1;
            end
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= reset_m();
        else m <= step(m, s_valid, s_chan, s_data, s_last, err_clr);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (run) begin
            chk("s_ready", 32'(s_ready), 32'(rst_n && rdy(m, s_chan)));
            chk("data_en", 32'(data_en), 32'(m.en));
            chk("data_in_a", 32'(data_in_a), 32'(m.a));
            chk("data_in_b", 32'(data_in_b), 32'(m.b));
            chk("switch", 32'(switch), 32'(m.sw));
            chk("frame_done", 32'(frame_done), 32'(m.done));
            chk("err_short", 32'(err_short), 32'(m.es));
            chk("err_long", 32'(err_long), 32'(m.el));
            if (frame_done === 1'b1) n_done++;
        end
    end

    task automatic tick();
        err_clr = rnd_clr ? ($urandom_range(0, 15) == 0) : 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        s_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            s_data = 16'($urandom);
            s_chan = 1'($urandom);
            s_last = 1'($urandom);
            tick();
        end
    endtask

    task automatic send(input logic ch, input logic [15:0] d, input logic last,
                        output int waits);
        s_valid = 1'b1;
        s_chan  = ch;
        s_data  = d;
        s_last  = last;
        waits   = 0;
        for (int i = 0; i < 64; i++) begin
            tick();
            if (m.en) return;
            waits++;
        end
        checks++;
        fails++;
        $display("FAIL accept_timeout: word %0h not accepted within 64 cycles", d);
    endtask

    task automatic frame(input logic ch, input logic [15:0] base, input int n,
                         input bit with_last, input int gap_max);
        int w;
        for (int i = 0; i < n; i++) begin
            if (gap_max > 0) idle(int'($urandom_range(0, gap_max)));
            send(ch, base + 16'(i), with_last && (i == n - 1), w);
        end
    endtask

    task automatic clr_pulse();
        s_valid = 1'b0;
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
    endtask

    initial begin
        int  w;
        logic cur;
        s_valid = 0; s_chan = 0; s_data = '0; s_last = 0; err_clr = 0;
        repeat (2) @(posedge clk);
        run = 1;
        @(negedge clk);
        #1;
        chk("rst_data_en", 32'(data_en), 0);
        chk("rst_data_in_a", 32'(data_in_a), 0);
        chk("rst_data_in_b", 32'(data_in_b), 0);
        chk("rst_switch", 32'(switch), 0);
        chk("rst_frame_done", 32'(frame_done), 0);
        chk("rst_errs", {30'd0, err_short, err_long}, 0);
        chk("rst_s_ready", 32'(s_ready), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Normal A frame
        frame(1'b0, 16'h0001, 8, 1, 0);
        chk("a_done", 32'(frame_done), 1);
        chk("a_last_word", 32'(data_in_a), 32'h0008);
        idle(2);
        chk("a_b_untouched", 32'(data_in_b), 0);
        chk("a_switch", 32'(switch), 0);
        chk("a_frames", 32'(n_done), 1);

        // Channel change to B
        send(1'b1, 16'h0B00, 1'b0, w);
        chk("chg_block_cycles", 32'(w), 5);
        chk("chg_switch", 32'(switch), 1);
        for (int i = 1; i < 8; i++) send(1'b1, 16'h0B00 + 16'(i), i == 7, w);
        chk("b_last_word", 32'(data_in_b), 32'h0B07);
        chk("b_a_holds", 32'(data_in_a), 32'h0008);
        chk("b_errs", {30'd0, err_short, err_long}, 0);

        // Short frame, then clear
        frame(1'b1, 16'h5000, 5, 1, 0);
        chk("short_flag", 32'(err_short), 1);
        chk("short_done", 32'(frame_done), 1);
        clr_pulse();
        chk("short_cleared", 32'(err_short), 0);
        frame(1'b1, 16'h6000, 8, 1, 0);
        chk("after_short_ok", {30'd0, err_short, err_long}, 0);

        // Long frame: 8 words force an end, 2+6 more form a normal frame
        frame(1'b1, 16'h7000, 8, 0, 0);
        chk("long_flag", 32'(err_long), 1);
        chk("long_done", 32'(frame_done), 1);
        frame(1'b1, 16'h7008, 2, 0, 0);
        chk("long_next_nodone", 32'(frame_done), 0);
        frame(1'b1, 16'h700A, 6, 1, 0);
        chk("long_next_done", 32'(frame_done), 1);
        chk("long_next_noshort", 32'(err_short), 0);
        chk("long_next_word", 32'(data_in_b), 32'h700F);
        clr_pulse();
        chk("long_cleared", 32'(err_long), 0);

        // Backpressure gaps mid-frame
        frame(1'b1, 16'h8000, 8, 1, 3);
        chk("bp_done", 32'(frame_done), 1);
        chk("bp_errs", {30'd0, err_short, err_long}, 0);
        chk("bp_last_word", 32'(data_in_b), 32'h8007);

        // Reset while guarding a change back to A
        idle(1);
        s_valid = 1'b1; s_chan = 1'b0; s_data = 16'h9999; s_last = 1'b0;
        tick();
        tick();
        chk("pre_rst_switch", 32'(switch), 1);
        rst_n = 1'b0;
        s_valid = 1'b0;
        #1;
        chk("mid_rst_switch", 32'(switch), 0);
        chk("mid_rst_data", {data_in_a, data_in_b}, 0);
        chk("mid_rst_flags", {29'd0, data_en, frame_done, err_short | err_long}, 0);
        tick();
        tick();
        rst_n = 1'b1;
        idle(2);

        // Randomised stream
        rnd_clr = 1;
        cur = 1'b0;
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 9) == 0) cur = ~cur;
            if ($urandom_range(0, 4) == 0) idle(int'($urandom_range(1, 3)));
            send(($urandom_range(0, 3) == 0) ? ~cur : cur, 16'($urandom),
                 ($urandom_range(0, 6) == 0), w);
        end
        rnd_clr = 0;
        idle(4);
        run = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
